// File: rtl/hs_flow_out_packer.sv
// hs_flow_out_packer: frames the optical-flow result stream (frame_sync + U/V per cycle) into a
// ready/valid stream tagged with SOF/EOF, buffered in a small FIFO, with sticky error flags.
// Optional feature: define FLOW_PACK_CHECKSUM_EN to add io_checksum, a per-frame running sum
// of (u ^ v) latched when a frame completes.
module hs_flow_out_packer #(
    parameter int unsigned IMG_W      = 512,
    parameter int unsigned IMG_H      = 256,
    parameter int unsigned FP_WIDTH   = 26,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                io_frame_sync_in,
    input  logic [FP_WIDTH-1:0] io_data_u,
    input  logic [FP_WIDTH-1:0] io_data_v,
    input  logic                io_out_ready,
    output logic                io_out_valid,
    output logic [FP_WIDTH-1:0] io_out_bits_u,
    output logic [FP_WIDTH-1:0] io_out_bits_v,
    output logic                io_out_sof,
    output logic                io_out_eof,
    output logic                io_overflow,
    output logic                io_sync_err,
`ifdef FLOW_PACK_CHECKSUM_EN
    output logic [31:0]         io_checksum,
`endif
    output logic [15:0]         io_frame_count
);

    localparam int unsigned NPix  = IMG_W * IMG_H;
    localparam int unsigned CntW  = (NPix > 1) ? $clog2(NPix) : 1;
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;
    localparam int unsigned EntW  = 2 * FP_WIDTH + 2;

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              overflow_q, overflow_d;
    logic              sync_err_q, sync_err_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [EntW-1:0]   mem_q [FIFO_DEPTH];

    logic              in_stream, last_pix, first_pix;
    logic              fifo_empty, fifo_full, pop, push_ok;
    logic [EntW-1:0]   head;

    assign in_stream  = (state_q == StStream);
    assign last_pix   = (pix_cnt_q == CntW'(NPix - 1));
    assign first_pix  = (pix_cnt_q == '0);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    // Full when pointers differ only in the wrap bit.
    assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                        (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign pop        = !fifo_empty && io_out_ready;
    assign push_ok    = in_stream && (!fifo_full || pop);
    assign head       = mem_q[rd_ptr_q[AddrW-1:0]];

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // FSM next state: sync starts a frame; the last pixel ends it unless a new sync coincides
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (io_frame_sync_in) state_d = StStream;
            StStream: if (last_pix && !io_frame_sync_in) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath next state: pixel counter, frame counter, sticky flags, FIFO pointers
    always_comb begin
        pix_cnt_d   = '0;
        frame_cnt_d = frame_cnt_q;
        overflow_d  = overflow_q;
        sync_err_d  = sync_err_q;
        wr_ptr_d    = wr_ptr_q + PtrW'(push_ok);
        rd_ptr_d    = rd_ptr_q + PtrW'(pop);
        if (in_stream) begin
            // Counter keeps running through drops; sync or last pixel restarts at pixel 0.
            if (!last_pix && !io_frame_sync_in) pix_cnt_d = pix_cnt_q + CntW'(1);
            if (last_pix) frame_cnt_d = frame_cnt_q + 16'd1;
            if (io_frame_sync_in && !last_pix) sync_err_d = 1'b1;
            if (fifo_full && !pop) overflow_d = 1'b1;
        end
    end

    // Control/status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt_q   <= '0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
            sync_err_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            pix_cnt_q   <= pix_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
            sync_err_q  <= sync_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // FIFO storage; stale contents are masked by io_out_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= {first_pix, last_pix, io_data_u, io_data_v};
        end
    end

    // Output drive: head fields forced to zero while empty so reset shows all-zero outputs
    always_comb begin
        io_out_valid   = !fifo_empty;
        io_out_sof     = io_out_valid & head[EntW-1];
        io_out_eof     = io_out_valid & head[EntW-2];
        io_out_bits_u  = io_out_valid ? head[2*FP_WIDTH-1:FP_WIDTH] : '0;
        io_out_bits_v  = io_out_valid ? head[FP_WIDTH-1:0] : '0;
        io_overflow    = overflow_q;
        io_sync_err    = sync_err_q;
        io_frame_count = frame_cnt_q;
    end

`ifdef FLOW_PACK_CHECKSUM_EN
    logic [31:0] acc_q, acc_d, cks_q, cks_d, sum_now, pix_xor;

    assign pix_xor = 32'(io_data_u ^ io_data_v);
    assign sum_now = first_pix ? pix_xor : (acc_q + pix_xor);

    // Checksum accumulate; result published only when a frame reaches its last pixel
    always_comb begin
        acc_d = acc_q;
        cks_d = cks_q;
        if (in_stream) begin
            acc_d = sum_now;
            if (last_pix) cks_d = sum_now;
        end
    end

    // Checksum registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            cks_q <= '0;
        end else begin
            acc_q <= acc_d;
            cks_q <= cks_d;
        end
    end

    assign io_checksum = cks_q;
`endif

endmodule

// File: tb/tb_hs_flow_out_packer.sv
// Directed bench for hs_flow_out_packer (IMG_W=4, IMG_H=2, FIFO_DEPTH=4).
module tb_hs_flow_out_packer;

    localparam int unsigned W = 26;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         io_frame_sync_in = 1'b0;
    logic [W-1:0] io_data_u = '0;
    logic [W-1:0] io_data_v = '0;
    logic         io_out_ready = 1'b0;
    logic         io_out_valid;
    logic [W-1:0] io_out_bits_u;
    logic [W-1:0] io_out_bits_v;
    logic         io_out_sof;
    logic         io_out_eof;
    logic         io_overflow;
    logic         io_sync_err;
    logic [15:0]  io_frame_count;
`ifdef FLOW_PACK_CHECKSUM_EN
    logic [31:0]  io_checksum;
`endif

    hs_flow_out_packer #(
        .IMG_W(4), .IMG_H(2), .FP_WIDTH(W), .FIFO_DEPTH(4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .io_frame_sync_in (io_frame_sync_in),
        .io_data_u        (io_data_u),
        .io_data_v        (io_data_v),
        .io_out_ready     (io_out_ready),
        .io_out_valid     (io_out_valid),
        .io_out_bits_u    (io_out_bits_u),
        .io_out_bits_v    (io_out_bits_v),
        .io_out_sof       (io_out_sof),
        .io_out_eof       (io_out_eof),
        .io_overflow      (io_overflow),
        .io_sync_err      (io_sync_err),
`ifdef FLOW_PACK_CHECKSUM_EN
        .io_checksum      (io_checksum),
`endif
        .io_frame_count   (io_frame_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] u;
        logic [W-1:0] v;
        logic         sof;
        logic         eof;
    } beat_t;

    beat_t beats[$];
    int    passed = 0;
    int    total  = 0;

    // Record accepted beats mid-cycle, away from the clock edge
    always @(negedge clk) begin
        if (!reset && io_out_valid && io_out_ready)
            beats.push_back('{u: io_out_bits_u, v: io_out_bits_v, sof: io_out_sof,
                              eof: io_out_eof});
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [W-1:0] u, input logic [W-1:0] v, input logic s);
        io_data_u        = u;
        io_data_v        = v;
        io_frame_sync_in = s;
        cycle();
    endtask

    task automatic idle(input int n);
        io_frame_sync_in = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        io_frame_sync_in = 1'b0;
        io_out_ready     = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
        beats.delete();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({io_out_valid, io_out_sof, io_out_eof, io_overflow, io_sync_err} !== 5'b0)
            $display("FAIL reset_flags got=%b want=00000",
                     {io_out_valid, io_out_sof, io_out_eof, io_overflow, io_sync_err});
        else passed++;
        total++;
        if (io_frame_count !== 16'd0 || io_out_bits_u !== '0 || io_out_bits_v !== '0)
            $display("FAIL reset_data count=%0d u=%0d v=%0d want 0", io_frame_count,
                     io_out_bits_u, io_out_bits_v);
        else passed++;
    endtask

    task automatic test_single_frame();
        beat_t exp;
        do_reset();
        io_out_ready = 1'b1;
        pix('0, '0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            pix(W'(i), W'(8 - i), 1'b0);
            if (i == 0) begin
                total++;
                if (io_out_valid !== 1'b1 || io_out_bits_u !== '0 || io_out_sof !== 1'b1)
                    $display("FAIL latency valid=%b u=%0d sof=%b want 1/0/1", io_out_valid,
                             io_out_bits_u, io_out_sof);
                else passed++;
            end
        end
        total++;
        if (io_frame_count !== 16'd1)
            $display("FAIL frame1_count got=%0d want=1", io_frame_count);
        else passed++;
        idle(3);
        total++;
        if (beats.size() != 8)
            $display("FAIL frame1_beats got=%0d want=8", beats.size());
        else passed++;
        for (int i = 0; i < 8 && i < beats.size(); i++) begin
            exp = '{u: W'(i), v: W'(8 - i), sof: (i == 0), eof: (i == 7)};
            total++;
            if (beats[i] !== exp)
                $display("FAIL frame1_beat%0d got=%h want=%h", i, beats[i], exp);
            else passed++;
        end
    endtask

    task automatic test_overflow();
        beat_t exp;
        do_reset();
        pix('0, '0, 1'b1);
        for (int i = 0; i < 8; i++) pix(W'(i), '0, 1'b0);
        idle(1);
        total++;
        if (io_overflow !== 1'b1 || io_out_valid !== 1'b1 || io_out_bits_u !== '0)
            $display("FAIL ovf_flag ovf=%b valid=%b u=%0d want 1/1/0", io_overflow,
                     io_out_valid, io_out_bits_u);
        else passed++;
        total++;
        if (io_frame_count !== 16'd1)
            $display("FAIL ovf_count got=%0d want=1", io_frame_count);
        else passed++;
        io_out_ready = 1'b1;
        idle(6);
        total++;
        if (beats.size() != 4 || io_out_valid !== 1'b0)
            $display("FAIL ovf_drain beats=%0d valid=%b want 4/0", beats.size(), io_out_valid);
        else passed++;
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            exp = '{u: W'(i), v: '0, sof: (i == 0), eof: 1'b0};
            total++;
            if (beats[i] !== exp)
                $display("FAIL ovf_beat%0d got=%h want=%h", i, beats[i], exp);
            else passed++;
        end
    endtask

    task automatic test_sync_err();
        beat_t exp;
        int    eu[13];
        for (int i = 0; i < 5; i++) eu[i] = i;
        for (int i = 0; i < 8; i++) eu[5 + i] = 100 + i;
        do_reset();
        io_out_ready = 1'b1;
        pix('0, '0, 1'b1);
        for (int i = 0; i < 4; i++) pix(W'(i), '0, 1'b0);
        pix(W'(4), '0, 1'b1);
        total++;
        if (io_sync_err !== 1'b1 || io_frame_count !== 16'd0)
            $display("FAIL sync_err err=%b count=%0d want 1/0", io_sync_err, io_frame_count);
        else passed++;
        for (int i = 0; i < 8; i++) pix(W'(100 + i), '0, 1'b0);
        idle(3);
        total++;
        if (beats.size() != 13 || io_frame_count !== 16'd1)
            $display("FAIL sync_beats beats=%0d count=%0d want 13/1", beats.size(),
                     io_frame_count);
        else passed++;
        for (int i = 0; i < 13 && i < beats.size(); i++) begin
            exp = '{u: W'(eu[i]), v: '0, sof: (i == 0 || i == 5), eof: (i == 12)};
            total++;
            if (beats[i] !== exp)
                $display("FAIL sync_beat%0d got=%h want=%h", i, beats[i], exp);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        pix('0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            io_out_ready = (i == 1 || i == 2);
            pix(W'(i), '0, 1'b0);
        end
        io_out_ready = 1'b0;
        total++;
        if (io_out_valid !== 1'b1 || io_out_bits_u !== W'(2) || io_overflow !== 1'b0)
            $display("FAIL pre_reset valid=%b u=%0d ovf=%b want 1/2/0", io_out_valid,
                     io_out_bits_u, io_overflow);
        else passed++;
        io_data_u = W'(5);
        reset     = 1'b1;
        cycle();
        total++;
        if ({io_out_valid, io_overflow, io_sync_err} !== 3'b0 || io_frame_count !== 16'd0)
            $display("FAIL mid_reset flags=%b count=%0d want 000/0",
                     {io_out_valid, io_overflow, io_sync_err}, io_frame_count);
        else passed++;
        reset        = 1'b0;
        io_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) pix(W'(7), W'(7), 1'b0);
        total++;
        if (io_out_valid !== 1'b0)
            $display("FAIL idle_no_push valid=%b want 0", io_out_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        beat_t exp;
        int    k;
        do_reset();
        io_out_ready = 1'b1;
        pix('0, '0, 1'b1);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                k = f * 8 + i;
                // Three stalls fill the 4-deep FIFO exactly; later cycles push while full+pop.
                io_out_ready = !(k == 3 || k == 8 || k == 12);
                pix(W'(f * 16 + i), W'(i), (f == 0 && i == 7));
            end
        end
        io_out_ready = 1'b1;
        idle(6);
        total++;
        if (beats.size() != 16 || io_frame_count !== 16'd2)
            $display("FAIL b2b_beats beats=%0d count=%0d want 16/2", beats.size(),
                     io_frame_count);
        else passed++;
        total++;
        if (io_overflow !== 1'b0 || io_sync_err !== 1'b0)
            $display("FAIL b2b_flags ovf=%b err=%b want 0/0", io_overflow, io_sync_err);
        else passed++;
        for (int j = 0; j < 16 && j < beats.size(); j++) begin
            exp = '{u: W'((j / 8) * 16 + (j % 8)), v: W'(j % 8), sof: (j % 8 == 0),
                    eof: (j % 8 == 7)};
            total++;
            if (beats[j] !== exp)
                $display("FAIL b2b_beat%0d got=%h want=%h", j, beats[j], exp);
            else passed++;
        end
    endtask

`ifdef FLOW_PACK_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        io_out_ready = 1'b1;
        pix('0, '0, 1'b1);
        for (int i = 0; i < 7; i++) pix(W'(i), '0, 1'b0);
        total++;
        if (io_checksum !== 32'd0)
            $display("FAIL cks_early got=%0d want=0", io_checksum);
        else passed++;
        pix(W'(7), '0, 1'b0);
        total++;
        if (io_checksum !== 32'd28)
            $display("FAIL cks_frame got=%0d want=28", io_checksum);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_sync_err();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef FLOW_PACK_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
